rs_chien_ctrl: RTL and testbench
================================

Name: rs_chien_ctrl

Overview:
Sequencer for the multicycle Chien search datapath (rs_chien). It accepts an error-locator polynomial and its degree from the key-equation solver, sweeps the root space alpha^0..alpha^(2^SYMB_WIDTH-2) one slice of ROOTS_PER_CYCLE roots per cycle, and collects flagged lanes into up to T_LEN root exponents. It presents the result to the Forney stage with a valid/ready handshake and checks the root count against the locator degree.

Parameters:
SYMB_WIDTH, 8, symbol width m; root space N = 2^m-1 (255)
T_LEN, 8, max correctable errors / result slots
ROOTS_PER_CYCLE, 32, roots evaluated per slice
CYCLES_NUM, 8, slices per sweep = ceil(N/ROOTS_PER_CYCLE)
CHIEN_LAT, 1, datapath latency, slice issue to error_bit_pos (>=1)

Ports:
aclk  in  1  clock
areset  in  1  synchronous, active-high reset
error_locator  in  SYMB_WIDTH x (T_LEN+1)  locator coefficients, index 0 = constant term
locator_deg  in  $clog2(T_LEN+1)  locator degree
error_locator_vld  in  1  upstream valid
error_locator_rdy  out  1  upstream ready
chien_locator  out  SYMB_WIDTH x (T_LEN+1)  registered locator to datapath
chien_base  out  SYMB_WIDTH+1  exponent of lane 0 in the current slice
chien_lane_mask  out  ROOTS_PER_CYCLE  lanes with exponent < N
chien_slice_vld  out  1  slice issued this cycle
error_bit_pos  in  ROOTS_PER_CYCLE  per-lane root flags from datapath
error_positions  out  SYMB_WIDTH x T_LEN  root exponents, ascending
error_cnt  out  $clog2(T_LEN+1)  roots stored
error_positions_vld  out  1  result valid
error_positions_rdy  in  1  downstream ready
rs_chien_err  out  1  uncorrectable flag, valid with error_positions_vld

Behaviour:
- Reset (sync, areset=1 at an aclk edge): state IDLE, every output 0 except error_locator_rdy=1 from the first edge after reset. All slots and counters cleared. Reset mid-sweep aborts the sweep, drops in-flight datapath results, and issues no output.
- FSM states: IDLE, SWEEP, DRAIN, DONE.
- IDLE: error_locator_rdy=1. On vld&rdy, latch error_locator and locator_deg, clear slots and error_cnt, reset slice counter k=0.
- IDLE exit: if locator_deg==0, go to DONE with error_cnt=0 and rs_chien_err=0. Otherwise go to SWEEP.
- SWEEP: error_locator_rdy=0. Each cycle chien_slice_vld=1 and chien_base=k*ROOTS_PER_CYCLE.
- chien_lane_mask bit j = (chien_base+j < N), computed in SYMB_WIDTH+1 bits. Last slice with defaults: base 224, lanes 0..30 set, lane 31 clear.
- SWEEP exit: after slice CYCLES_NUM-1, go to DRAIN.
- Response tracking: a CHIEN_LAT-deep shift register carries slice_vld, base and mask. error_bit_pos is sampled only when the delayed valid is high, and ANDed with the delayed mask.
- Collection: scan set lanes in ascending j. Lane j's exponent is base+j, truncated to SYMB_WIDTH bits. It is written to slot error_cnt+r, where r is the rank of lane j among set lanes in that slice, only if error_cnt+r < T_LEN. error_cnt increments by the number written.
- Overflow: if any set lane cannot be stored (error_cnt+r >= T_LEN), set the sticky overflow bit.
- DRAIN: hold until the last delayed slice is sampled, then go to DONE. Entry to DONE falls exactly CYCLES_NUM+CHIEN_LAT cycles after the accept edge.
- DONE: error_positions_vld=1. Outputs are stable while vld&&!rdy. rs_chien_err = overflow || (error_cnt != latched locator_deg).
- DONE exit: on error_positions_rdy, go to IDLE. error_locator_rdy rises the cycle after the handshake; there is no same-cycle re-accept.
- Unused slots read 0.
- error_bit_pos is ignored outside tracked cycles.
- chien_locator is held constant from accept until the IDLE return.
- Throughput: one codeword per CYCLES_NUM+CHIEN_LAT+2 cycles minimum.

Test Plan:
- No errors: locator {1,0..}, deg=0 -> vld one cycle after accept, error_cnt=0, rs_chien_err=0, no chien_slice_vld pulses.
- Two roots: deg=2; model returns bits for exponents 5 and 200 (slice 0 lane 5, slice 6 lane 8) -> vld at accept+9 (defaults), positions {5,200,0..}, cnt=2, err=0.
- Mask check: datapath drives all-ones on every slice -> lane 31 of slice 7 is ignored. First 8 stored positions are 0..7, overflow set, err=1, and chien_base sequence is 0,32,..,224.
- Degree mismatch: deg=3, only exponents 10 and 11 flagged (same slice) -> cnt=2, positions {10,11}, err=1.
- Backpressure: hold error_positions_rdy=0 for 5 cycles in DONE -> vld and positions stable, rdy stays 0. A new locator_vld asserted meanwhile is accepted only after the output handshake, on the following cycle.
- Reset mid-sweep: assert areset at slice 3 -> next edge all outputs 0 and rdy=1. A subsequent clean codeword yields the correct result, unaffected by stale in-flight bits.

Source files
------------

// File: rtl/rs_chien_ctrl.sv
// Chien search sequencer: issues root-space slices to the datapath, gathers
// flagged lanes into ascending root exponents and hands them to Forney.
module rs_chien_ctrl #(
  parameter int SYMB_WIDTH      = 8,
  parameter int T_LEN           = 8,
  parameter int ROOTS_PER_CYCLE = 32,
  parameter int CYCLES_NUM      = 8,
  parameter int CHIEN_LAT       = 1
) (
  input  logic                                   aclk,
  input  logic                                   areset,
  input  logic [T_LEN:0][SYMB_WIDTH-1:0]         error_locator,
  input  logic [$clog2(T_LEN+1)-1:0]             locator_deg,
  input  logic                                   error_locator_vld,
  output logic                                   error_locator_rdy,
  output logic [T_LEN:0][SYMB_WIDTH-1:0]         chien_locator,
  output logic [SYMB_WIDTH:0]                    chien_base,
  output logic [ROOTS_PER_CYCLE-1:0]             chien_lane_mask,
  output logic                                   chien_slice_vld,
  input  logic [ROOTS_PER_CYCLE-1:0]             error_bit_pos,
  output logic [T_LEN-1:0][SYMB_WIDTH-1:0]       error_positions,
  output logic [$clog2(T_LEN+1)-1:0]             error_cnt,
  output logic                                   error_positions_vld,
  input  logic                                   error_positions_rdy,
  output logic                                   rs_chien_err
);

  localparam int CNT_W = $clog2(T_LEN + 1);
  localparam int IDX_W = (T_LEN > 1) ? $clog2(T_LEN) : 1;
  localparam int K_W   = (CYCLES_NUM > 1) ? $clog2(CYCLES_NUM) : 1;
  localparam logic [SYMB_WIDTH:0] N_ROOTS = (SYMB_WIDTH+1)'((1 << SYMB_WIDTH) - 1);

  typedef enum logic [1:0] {IDLE, SWEEP, DRAIN, DONE} state_t;

  state_t                          state;
  state_t                          state_nx;
  logic                            accept;
  logic                            slice_last;
  logic [K_W-1:0]                  k_r;
  logic [CNT_W-1:0]                deg_r;
  logic [CNT_W-1:0]                cnt_r;
  logic [CNT_W-1:0]                cnt_nx;
  logic                            ovf_r;
  logic                            ovf_nx;
  logic [T_LEN-1:0][SYMB_WIDTH-1:0] slots_r;
  logic [T_LEN-1:0][SYMB_WIDTH-1:0] slots_nx;
  logic [ROOTS_PER_CYCLE-1:0]      hits;

  // Response tracking: slice context delayed to line up with error_bit_pos
  logic [CHIEN_LAT-1:0]            vld_p;
  logic [CHIEN_LAT-1:0]            last_p;
  logic [SYMB_WIDTH-1:0]           base_p [CHIEN_LAT];
  logic [ROOTS_PER_CYCLE-1:0]      mask_p [CHIEN_LAT];

  assign accept     = (state == IDLE) && error_locator_vld;
  assign slice_last = (k_r == K_W'(CYCLES_NUM - 1));

  always_ff @(posedge aclk) begin
    if (areset) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: begin
        if (error_locator_vld) begin
          state_nx = (locator_deg == '0) ? DONE : SWEEP;
        end
      end
      SWEEP: begin
        if (slice_last) begin
          state_nx = DRAIN;
        end
      end
      DRAIN: begin
        if (vld_p[CHIEN_LAT-1] && last_p[CHIEN_LAT-1]) begin
          state_nx = DONE;
        end
      end
      DONE: begin
        if (error_positions_rdy) begin
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    error_locator_rdy   = 1'b0;
    chien_slice_vld     = 1'b0;
    error_positions_vld = 1'b0;
    rs_chien_err        = 1'b0;
    case (state)
      IDLE:  error_locator_rdy = 1'b1;
      SWEEP: chien_slice_vld   = 1'b1;
      DONE: begin
        error_positions_vld = 1'b1;
        rs_chien_err        = ovf_r || (cnt_r != deg_r);
      end
      default: ;
    endcase
  end

  // Slice issue: base and in-range lane mask, zero when idle
  always_comb begin
    chien_base      = '0;
    chien_lane_mask = '0;
    if (chien_slice_vld) begin
      chien_base = (SYMB_WIDTH+1)'(k_r) * (SYMB_WIDTH+1)'(ROOTS_PER_CYCLE);
      for (int j = 0; j < ROOTS_PER_CYCLE; j++) begin
        chien_lane_mask[j] = (chien_base + (SYMB_WIDTH+1)'(j)) < N_ROOTS;
      end
    end
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      vld_p  <= '0;
      last_p <= '0;
    end else begin
      vld_p[0]  <= chien_slice_vld;
      last_p[0] <= chien_slice_vld && slice_last;
      for (int i = 1; i < CHIEN_LAT; i++) begin
        vld_p[i]  <= vld_p[i-1];
        last_p[i] <= last_p[i-1];
      end
    end
  end

  always_ff @(posedge aclk) begin
    base_p[0] <= chien_base[SYMB_WIDTH-1:0];
    mask_p[0] <= chien_lane_mask;
    for (int i = 1; i < CHIEN_LAT; i++) begin
      base_p[i] <= base_p[i-1];
      mask_p[i] <= mask_p[i-1];
    end
  end

  // Collection: set lanes in ascending order fill the next free slots
  always_comb begin
    hits     = vld_p[CHIEN_LAT-1] ? (error_bit_pos & mask_p[CHIEN_LAT-1]) : '0;
    slots_nx = slots_r;
    cnt_nx   = cnt_r;
    ovf_nx   = ovf_r;
    for (int j = 0; j < ROOTS_PER_CYCLE; j++) begin
      if (hits[j]) begin
        if (cnt_nx < CNT_W'(T_LEN)) begin
          slots_nx[cnt_nx[IDX_W-1:0]] = base_p[CHIEN_LAT-1] + SYMB_WIDTH'(j);
          cnt_nx = cnt_nx + CNT_W'(1);
        end else begin
          ovf_nx = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      chien_locator <= '0;
      deg_r         <= '0;
      k_r           <= '0;
      slots_r       <= '0;
      cnt_r         <= '0;
      ovf_r         <= 1'b0;
    end else if (accept) begin
      chien_locator <= error_locator;
      deg_r         <= locator_deg;
      k_r           <= '0;
      slots_r       <= '0;
      cnt_r         <= '0;
      ovf_r         <= 1'b0;
    end else begin
      slots_r <= slots_nx;
      cnt_r   <= cnt_nx;
      ovf_r   <= ovf_nx;
      if (chien_slice_vld) begin
        k_r <= k_r + K_W'(1);
      end
    end
  end

  assign error_positions = slots_r;
  assign error_cnt       = cnt_r;

endmodule

// File: tb/tb_rs_chien_ctrl.sv
// Directed bench for rs_chien_ctrl with a one-cycle datapath model driven
// from a table of root exponents.
module tb_rs_chien_ctrl;
  localparam int SW  = 8;
  localparam int TL  = 8;
  localparam int RPC = 32;
  localparam int CN  = 8;
  localparam int LAT = 1;

  logic                     aclk = 1'b0;
  logic                     areset;
  logic [TL:0][SW-1:0]      error_locator;
  logic [3:0]               locator_deg;
  logic                     error_locator_vld;
  logic                     error_locator_rdy;
  logic [TL:0][SW-1:0]      chien_locator;
  logic [SW:0]              chien_base;
  logic [RPC-1:0]           chien_lane_mask;
  logic                     chien_slice_vld;
  logic [RPC-1:0]           error_bit_pos = '1;
  logic [TL-1:0][SW-1:0]    error_positions;
  logic [3:0]               error_cnt;
  logic                     error_positions_vld;
  logic                     error_positions_rdy;
  logic                     rs_chien_err;

  int errors = 0;
  int checks = 0;
  int slice_pulses = 0;
  int p0;
  int lat;
  logic [254:0]        root_set;
  logic                all_ones;
  logic                lane_hi;
  logic [TL:0][SW-1:0] loc;

  always #5 aclk = ~aclk;

  rs_chien_ctrl #(
    .SYMB_WIDTH(SW), .T_LEN(TL), .ROOTS_PER_CYCLE(RPC), .CYCLES_NUM(CN), .CHIEN_LAT(LAT)
  ) dut (
    .aclk(aclk), .areset(areset),
    .error_locator(error_locator), .locator_deg(locator_deg),
    .error_locator_vld(error_locator_vld), .error_locator_rdy(error_locator_rdy),
    .chien_locator(chien_locator), .chien_base(chien_base),
    .chien_lane_mask(chien_lane_mask), .chien_slice_vld(chien_slice_vld),
    .error_bit_pos(error_bit_pos), .error_positions(error_positions),
    .error_cnt(error_cnt), .error_positions_vld(error_positions_vld),
    .error_positions_rdy(error_positions_rdy), .rs_chien_err(rs_chien_err)
  );

  function automatic logic [RPC-1:0] model_bits(input logic [SW:0] base);
    logic [RPC-1:0] b;
    int e;
    b = '0;
    for (int j = 0; j < RPC; j++) begin
      e = int'(base) + j;
      if (all_ones)     b[j] = 1'b1;
      else if (e < 255) b[j] = root_set[e];
      else              b[j] = lane_hi;
    end
    return b;
  endfunction

  // Datapath model: one cycle from slice issue; noise when no slice was issued
  always @(posedge aclk) begin
    error_bit_pos <= chien_slice_vld ? model_bits(chien_base) : '1;
    if (chien_slice_vld) slice_pulses <= slice_pulses + 1;
  end

  task automatic chk(input string tag, input logic [71:0] obs, input logic [71:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic accept_cw(input logic [TL:0][SW-1:0] l, input logic [3:0] d);
    chk("acc_rdy", error_locator_rdy, 1);
    error_locator     = l;
    locator_deg       = d;
    error_locator_vld = 1'b1;
    @(negedge aclk);
    error_locator_vld = 1'b0;
  endtask

  task automatic wait_done(output int n);
    n = 0;
    while (error_positions_vld !== 1'b1 && n < 40) begin
      @(negedge aclk);
      n++;
    end
  endtask

  task automatic release_out(input string tag);
    error_positions_rdy = 1'b1;
    @(negedge aclk);
    error_positions_rdy = 1'b0;
    chk({tag, "_vld_low"}, error_positions_vld, 0);
    chk({tag, "_rdy_back"}, error_locator_rdy, 1);
  endtask

  initial begin
    areset = 1'b1; error_locator_vld = 1'b0; error_locator = '0; locator_deg = '0;
    error_positions_rdy = 1'b0; root_set = '0; all_ones = 1'b0; lane_hi = 1'b0;
    repeat (2) @(negedge aclk);
    chk("rst_rdy", error_locator_rdy, 1);
    chk("rst_slice", chien_slice_vld, 0);
    chk("rst_vld", error_positions_vld, 0);
    chk("rst_cnt", error_cnt, 0);
    chk("rst_pos", error_positions, 0);
    chk("rst_err", rs_chien_err, 0);
    chk("rst_loc", chien_locator, 0);
    chk("rst_mask", chien_lane_mask, 0);
    areset = 1'b0;
    @(negedge aclk);

    // Degree 0: immediate result, no sweep
    p0 = slice_pulses;
    loc = '0; loc[0] = 8'd1;
    accept_cw(loc, 4'd0);
    chk("t1_vld", error_positions_vld, 1);
    chk("t1_cnt", error_cnt, 0);
    chk("t1_err", rs_chien_err, 0);
    chk("t1_slice", chien_slice_vld, 0);
    release_out("t1");
    chk("t1_pulses", slice_pulses - p0, 0);

    // Two roots at 5 and 200
    root_set = '0; root_set[5] = 1'b1; root_set[200] = 1'b1;
    p0 = slice_pulses;
    loc = 72'h010203040506070809;
    accept_cw(loc, 4'd2);
    chk("t2_loc", chien_locator, 72'h010203040506070809);
    wait_done(lat);
    chk("t2_lat", lat, 9);
    chk("t2_pos", error_positions, 64'h000000000000C805);
    chk("t2_cnt", error_cnt, 2);
    chk("t2_err", rs_chien_err, 0);
    chk("t2_pulses", slice_pulses - p0, 8);
    chk("t2_loc_hold", chien_locator, 72'h010203040506070809);
    release_out("t2");

    // All lanes flagged: base sequence, mask and overflow
    all_ones = 1'b1;
    accept_cw(loc, 4'd8);
    for (int k = 0; k < CN; k++) begin
      chk("t3_slice", chien_slice_vld, 1);
      chk("t3_base", chien_base, 72'(k * 32));
      if (k == 0)      chk("t3_mask0", chien_lane_mask, 32'hFFFFFFFF);
      if (k == CN - 1) chk("t3_mask7", chien_lane_mask, 32'h7FFFFFFF);
      @(negedge aclk);
    end
    chk("t3_drain_slice", chien_slice_vld, 0);
    wait_done(lat);
    chk("t3_lat", lat, 1);
    chk("t3_pos", error_positions, 64'h0706050403020100);
    chk("t3_cnt", error_cnt, 8);
    chk("t3_err", rs_chien_err, 1);
    release_out("t3");
    all_ones = 1'b0;

    // Out-of-range lane 31 of the last slice flagged alongside root 254
    root_set = '0; root_set[254] = 1'b1; lane_hi = 1'b1;
    accept_cw(loc, 4'd1);
    wait_done(lat);
    chk("t3b_lat", lat, 9);
    chk("t3b_pos", error_positions, 64'h00000000000000FE);
    chk("t3b_cnt", error_cnt, 1);
    chk("t3b_err", rs_chien_err, 0);
    release_out("t3b");
    lane_hi = 1'b0;

    // Degree mismatch: roots 10 and 11 in the same slice, degree 3
    root_set = '0; root_set[10] = 1'b1; root_set[11] = 1'b1;
    accept_cw(loc, 4'd3);
    wait_done(lat);
    chk("t4_lat", lat, 9);
    chk("t4_pos", error_positions, 64'h0000000000000B0A);
    chk("t4_cnt", error_cnt, 2);
    chk("t4_err", rs_chien_err, 1);
    release_out("t4");

    // Backpressure with a new locator waiting upstream
    root_set = '0; root_set[50] = 1'b1; root_set[60] = 1'b1;
    accept_cw(loc, 4'd2);
    wait_done(lat);
    chk("t5_lat", lat, 9);
    root_set = '0; root_set[130] = 1'b1;
    error_locator = 72'h0A0B0C0D0E0F101112;
    locator_deg = 4'd1;
    error_locator_vld = 1'b1;
    for (int i = 0; i < 5; i++) begin
      chk("t5_hold_vld", error_positions_vld, 1);
      chk("t5_hold_pos", error_positions, 64'h0000000000003C32);
      chk("t5_hold_rdy", error_locator_rdy, 0);
      chk("t5_hold_loc", chien_locator, 72'h010203040506070809);
      @(negedge aclk);
    end
    chk("t5_cnt", error_cnt, 2);
    chk("t5_err", rs_chien_err, 0);
    error_positions_rdy = 1'b1;
    @(negedge aclk);
    error_positions_rdy = 1'b0;
    chk("t5_vld_low", error_positions_vld, 0);
    chk("t5_rdy_back", error_locator_rdy, 1);
    chk("t5_no_reaccept", chien_slice_vld, 0);
    @(negedge aclk);
    error_locator_vld = 1'b0;
    chk("t5_accepted", chien_slice_vld, 1);
    chk("t5_rdy_low", error_locator_rdy, 0);
    chk("t5_new_loc", chien_locator, 72'h0A0B0C0D0E0F101112);
    wait_done(lat);
    chk("t5b_lat", lat, 9);
    chk("t5b_pos", error_positions, 64'h0000000000000082);
    chk("t5b_cnt", error_cnt, 1);
    release_out("t5b");

    // Reset during slice 3
    root_set = '0; root_set[40] = 1'b1; root_set[100] = 1'b1;
    accept_cw(loc, 4'd2);
    repeat (3) @(negedge aclk);
    chk("t6_base3", chien_base, 96);
    areset = 1'b1;
    @(negedge aclk);
    chk("t6_rdy", error_locator_rdy, 1);
    chk("t6_slice", chien_slice_vld, 0);
    chk("t6_base", chien_base, 0);
    chk("t6_vld", error_positions_vld, 0);
    chk("t6_cnt", error_cnt, 0);
    chk("t6_pos", error_positions, 0);
    chk("t6_err", rs_chien_err, 0);
    chk("t6_loc", chien_locator, 0);
    areset = 1'b0;
    @(negedge aclk);
    root_set = '0; root_set[7] = 1'b1;
    @(negedge aclk);
    chk("t6_idle_cnt", error_cnt, 0);
    chk("t6_idle_pos", error_positions, 0);
    accept_cw(loc, 4'd1);
    wait_done(lat);
    chk("t6b_lat", lat, 9);
    chk("t6b_pos", error_positions, 64'h0000000000000007);
    chk("t6b_cnt", error_cnt, 1);
    chk("t6b_err", rs_chien_err, 0);
    release_out("t6b");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
